// File: rtl/debug_cmd_bridge.sv
// Debug command bridge: receives opcode/address/data bytes on an inbound byte
// stream, performs one access on the debug bus (or a step/run/halt/status
// action), and returns a response on an outbound byte stream. Only one command
// is in flight at a time.
module debug_cmd_bridge #(
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        dbg_enable,
    output logic        dbg_rd_wr,
    output logic [31:0] dbg_address,
    output logic [31:0] dbg_wdata,
    input  logic [31:0] dbg_rdata,
    input  logic        dbg_halt,
    output logic        dbg_step,
    output logic        dbg_run,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, EXEC, WAIT_RD, RESP} state_t;

    localparam logic [7:0]  OP_WRITE  = 8'h01;
    localparam logic [7:0]  OP_READ   = 8'h02;
    localparam logic [7:0]  OP_STEP   = 8'h03;
    localparam logic [7:0]  OP_RUN    = 8'h04;
    localparam logic [7:0]  OP_HALT   = 8'h05;
    localparam logic [7:0]  OP_STATUS = 8'h06;
    localparam logic [7:0]  RSP_OK    = 8'hA5;
    localparam logic [7:0]  RSP_BAD   = 8'hEE;
    // Last count values: the counters run 0..N-1 so they fit the parameter ranges.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_LAST     = 3'(RD_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [7:0]  opcode_reg, opcode_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [15:0] timeout_cnt_reg, timeout_cnt_next;
    logic [2:0]  lat_cnt_reg, lat_cnt_next;
    logic [31:0] address_reg, address_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] resp_reg, resp_next;        // response bytes, next byte in [31:24]
    logic [2:0]  resp_left_reg, resp_left_next;
    logic        run_reg, run_next;
    logic        err_reg, err_next;
    logic        rx_fire;
    logic        tx_fire;

    // Stream handshakes; rx_ready is held low while reset is asserted.
    assign rx_ready = reset_n && (state_reg == IDLE || state_reg == ADDR || state_reg == DATA);
    assign tx_valid = (state_reg == RESP);
    assign tx_data  = resp_reg[31:24];
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;

    assign busy        = (state_reg != IDLE);
    assign dbg_address = address_reg;
    assign dbg_wdata   = wdata_reg;
    assign dbg_run     = run_reg;
    assign err         = err_reg;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: counters, shifted address/data, response buffer, run level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_reg      <= 8'h00;
            byte_cnt_reg    <= 2'd0;
            timeout_cnt_reg <= 16'd0;
            lat_cnt_reg     <= 3'd0;
            address_reg     <= 32'h0;
            wdata_reg       <= 32'h0;
            resp_reg        <= 32'h0;
            resp_left_reg   <= 3'd0;
            run_reg         <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            opcode_reg      <= opcode_next;
            byte_cnt_reg    <= byte_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            lat_cnt_reg     <= lat_cnt_next;
            address_reg     <= address_next;
            wdata_reg       <= wdata_next;
            resp_reg        <= resp_next;
            resp_left_reg   <= resp_left_next;
            run_reg         <= run_next;
            err_reg         <= err_next;
        end
    end

    // Next-state, next-register values and the single-cycle bus/step strobes.
    always_comb begin
        state_next       = state_reg;
        opcode_next      = opcode_reg;
        byte_cnt_next    = byte_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        lat_cnt_next     = lat_cnt_reg;
        address_next     = address_reg;
        wdata_next       = wdata_reg;
        resp_next        = resp_reg;
        resp_left_next   = resp_left_reg;
        run_next         = run_reg;
        err_next         = 1'b0;
        dbg_enable       = 1'b0;
        dbg_rd_wr        = 1'b0;
        dbg_step         = 1'b0;

        case (state_reg)
            IDLE: begin
                byte_cnt_next    = 2'd0;
                timeout_cnt_next = 16'd0;
                if (rx_fire) begin
                    opcode_next = rx_data;
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        state_next = ADDR;
                    end else if (rx_data >= OP_STEP && rx_data <= OP_STATUS) begin
                        state_next = EXEC;
                    end else begin
                        resp_next      = {RSP_BAD, 24'h0};
                        resp_left_next = 3'd1;
                        err_next       = 1'b1;
                        state_next     = RESP;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    address_next     = {address_reg[23:0], rx_data};
                    byte_cnt_next    = byte_cnt_reg + 2'd1;
                    timeout_cnt_next = 16'd0;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = (opcode_reg == OP_WRITE) ? DATA : EXEC;
                    end
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    err_next         = 1'b1;
                    timeout_cnt_next = 16'd0;
                    state_next       = IDLE;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    wdata_next       = {wdata_reg[23:0], rx_data};
                    byte_cnt_next    = byte_cnt_reg + 2'd1;
                    timeout_cnt_next = 16'd0;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = EXEC;
                    end
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    err_next         = 1'b1;
                    timeout_cnt_next = 16'd0;
                    state_next       = IDLE;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 16'd1;
                end
            end
            EXEC: begin
                resp_next      = {RSP_OK, 24'h0};
                resp_left_next = 3'd1;
                state_next     = RESP;
                case (opcode_reg)
                    OP_WRITE: begin
                        dbg_enable = 1'b1;
                        dbg_rd_wr  = 1'b1;
                    end
                    OP_READ: begin
                        dbg_enable   = 1'b1;
                        lat_cnt_next = 3'd0;
                        state_next   = WAIT_RD;
                    end
                    OP_STEP:   dbg_step = 1'b1;
                    OP_RUN:    run_next = 1'b1;
                    OP_HALT:   run_next = 1'b0;
                    OP_STATUS: resp_next = {6'b0, run_reg, dbg_halt, 24'h0};
                    default:   state_next = IDLE;
                endcase
            end
            WAIT_RD: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    resp_next      = dbg_rdata;
                    resp_left_next = 3'd4;
                    lat_cnt_next   = 3'd0;
                    state_next     = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 3'd1;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    resp_next      = {resp_reg[23:0], 8'h00};
                    resp_left_next = resp_left_reg - 3'd1;
                    if (resp_left_reg == 3'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Bench for debug_cmd_bridge: directed scenarios plus random commands, checked
// against a command-level model (expected bus accesses and response bytes).
module tb_debug_cmd_bridge;

    localparam int RD_LAT = 3;
    localparam int TMO    = 16;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        dbg_enable;
    logic        dbg_rd_wr;
    logic [31:0] dbg_address;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_halt;
    logic        dbg_step;
    logic        dbg_run;
    logic        busy;
    logic        err;

    debug_cmd_bridge #(.RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .dbg_enable(dbg_enable), .dbg_rd_wr(dbg_rd_wr),
        .dbg_address(dbg_address), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_halt(dbg_halt),
        .dbg_step(dbg_step), .dbg_run(dbg_run),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: expected response bytes and bus accesses, memory contents.
    logic [7:0]  exp_tx [0:1023];
    logic [7:0]  got_tx [0:1023];
    int          tx_wr = 0, tx_rd = 0;
    logic        eb_rw    [0:255];
    logic [31:0] eb_addr  [0:255];
    logic [31:0] eb_wdata [0:255];
    logic        gb_rw    [0:255];
    logic [31:0] gb_addr  [0:255];
    logic [31:0] gb_wdata [0:255];
    int          bus_wr = 0, bus_rd = 0;
    logic [31:0] mem [logic [31:0]];
    logic        exp_run = 1'b0;
    int          exp_err = 0, exp_steps = 0;

    // Monitor state.
    int          err_seen = 0, step_seen = 0, err_edge = 0, last_accept_edge = 0;
    int          rd_target = -1;
    logic [31:0] rd_addr = 32'h0;
    logic        err_prev = 1'b0, stall_prev = 1'b0, rx_fired = 1'b0, busy_s = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    logic [7:0]  cmd [0:8];
    int          cmd_len = 0;
    int          txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Per-cycle observation of DUT outputs, taken at the falling edge.
    task automatic sample();
        rx_fired = 1'b0;
        if (!reset_n) begin
            err_prev = 1'b0; stall_prev = 1'b0; busy_s = 1'b0;
            return;
        end
        busy_s = busy;
        if (rx_valid && rx_ready) begin
            rx_fired = 1'b1;
            last_accept_edge = cyc + 1;
        end
        chk("enable_step_exclusive", dbg_enable & dbg_step, 1'b0);
        if (!dbg_enable) chk("rd_wr_outside_write", dbg_rd_wr, 1'b0);
        if (dbg_enable) begin
            if (bus_rd >= bus_wr) begin
                chk("spurious_enable", dbg_enable, 1'b0);
            end else begin
                chk("bus_rd_wr", dbg_rd_wr, eb_rw[bus_rd]);
                chk("bus_addr", dbg_address, eb_addr[bus_rd]);
                if (eb_rw[bus_rd]) chk("bus_wdata", dbg_wdata, eb_wdata[bus_rd]);
                gb_rw[bus_rd] = dbg_rd_wr; gb_addr[bus_rd] = dbg_address; gb_wdata[bus_rd] = dbg_wdata;
                bus_rd++;
            end
            if (!dbg_rd_wr) begin
                rd_target = cyc + RD_LAT;
                rd_addr   = dbg_address;
            end
        end
        if (dbg_step) step_seen++;
        if (err) begin
            if (err_prev) chk("err_single_cycle", err, 1'b0);
            else begin err_seen++; err_edge = cyc; end
        end
        err_prev = err;
        if (stall_prev) begin
            chk("tx_hold_valid", tx_valid, 1'b1);
            chk("tx_hold_data", tx_data, stall_data);
        end
        if (tx_valid) chk("busy_during_resp", busy, 1'b1);
        if (tx_valid && tx_ready) begin
            if (tx_rd >= tx_wr) begin
                chk("spurious_tx", tx_valid, 1'b0);
            end else begin
                chk("tx_byte", tx_data, exp_tx[tx_rd]);
                chk("run_at_resp", dbg_run, exp_run);
                got_tx[tx_rd] = tx_data;
                tx_rd++;
            end
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
    endtask

    // One clock: observe, drive the read-data device, then move stream inputs.
    task automatic tick();
        @(negedge clk);
        sample();
        if (cyc == rd_target) dbg_rdata = mem_read(rd_addr);
        else dbg_rdata = $urandom;
        @(posedge clk);
        cyc++;
        #1;
        tx_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic load(input int n, input logic [71:0] w);
        cmd_len = n;
        for (int i = 0; i < n; i++) cmd[i] = w[8*(n-1-i) +: 8];
    endtask

    task automatic push_tx(input logic [7:0] b);
        exp_tx[tx_wr] = b; tx_wr++;
    endtask

    task automatic push_bus(input logic rw, input logic [31:0] a, input logic [31:0] d);
        eb_rw[bus_wr] = rw; eb_addr[bus_wr] = a; eb_wdata[bus_wr] = d; bus_wr++;
    endtask

    // Command-level reference: what a complete command must produce.
    task automatic model_cmd();
        logic [31:0] a, d, v;
        a = {cmd[1], cmd[2], cmd[3], cmd[4]};
        d = {cmd[5], cmd[6], cmd[7], cmd[8]};
        if (cmd[0] == 8'h01) begin
            push_bus(1'b1, a, d); mem[a] = d; push_tx(8'hA5);
        end else if (cmd[0] == 8'h02) begin
            push_bus(1'b0, a, 32'h0); v = mem_read(a);
            for (int i = 3; i >= 0; i--) push_tx(v[8*i +: 8]);
        end else if (cmd[0] == 8'h03) begin
            exp_steps++; push_tx(8'hA5);
        end else if (cmd[0] == 8'h04) begin
            exp_run = 1'b1; push_tx(8'hA5);
        end else if (cmd[0] == 8'h05) begin
            exp_run = 1'b0; push_tx(8'hA5);
        end else if (cmd[0] == 8'h06) begin
            push_tx({6'b0, exp_run, dbg_halt});
        end else begin
            exp_err++; push_tx(8'hEE);
        end
    endtask

    task automatic send_cmd(input int max_gap);
        int k;
        for (int i = 0; i < cmd_len; i++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            rx_valid = 1'b1;
            rx_data  = cmd[i];
            k = 0;
            do begin tick(); k++; end while (!rx_fired && k < 100);
            if (!rx_fired) chk("rx_accept", rx_fired, 1'b1);
            rx_valid = 1'b0;
        end
    endtask

    task automatic post_checks();
        chk("bus_count", bus_rd, bus_wr);
        chk("err_count", err_seen, exp_err);
        chk("step_count", step_seen, exp_steps);
        chk("run_level", dbg_run, exp_run);
    endtask

    task automatic run_cmd();
        int k;
        model_cmd();
        send_cmd(3);
        k = 0;
        while ((tx_rd < tx_wr || busy_s) && k < 400) begin tick(); k++; end
        chk("cmd_complete", tx_rd, tx_wr);
        post_checks();
        txn++;
        $display("txn %0d op=%02h bytes=%0d responses_total=%0d", txn, cmd[0], cmd_len, tx_rd);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_enable", dbg_enable, 1'b0);
        chk("rst_rd_wr", dbg_rd_wr, 1'b0);
        chk("rst_address", dbg_address, 32'h0);
        chk("rst_wdata", dbg_wdata, 32'h0);
        chk("rst_step", dbg_step, 1'b0);
        chk("rst_run", dbg_run, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
    endtask

    initial begin
        int t0, b0, s0, e0, k, r;
        logic [31:0] a, d;
        logic [7:0]  op;
        reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        dbg_rdata = 32'h0; dbg_halt = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        reset_n = 1'b1;
        #1;
        chk("rx_ready_after_reset", rx_ready, 1'b1);

        // Directed write.
        t0 = tx_wr; b0 = bus_wr;
        load(9, 72'h01_00_00_04_10_DE_AD_BE_EF);
        run_cmd();
        chk("lit_wr_rw", gb_rw[b0], 1'b1);
        chk("lit_wr_addr", gb_addr[b0], 32'h0000_0410);
        chk("lit_wr_data", gb_wdata[b0], 32'hDEAD_BEEF);
        chk("lit_wr_resp", got_tx[t0], 8'hA5);

        // Directed read with the device returning 0x12345678.
        mem[32'h8] = 32'h1234_5678;
        t0 = tx_wr;
        load(5, 72'h02_00_00_00_08);
        run_cmd();
        chk("lit_rd_b0", got_tx[t0], 8'h12);
        chk("lit_rd_b1", got_tx[t0+1], 8'h34);
        chk("lit_rd_b2", got_tx[t0+2], 8'h56);
        chk("lit_rd_b3", got_tx[t0+3], 8'h78);

        // RUN, STATUS, STEP, HALT with core not halted.
        dbg_halt = 1'b0;
        t0 = tx_wr; s0 = step_seen;
        load(1, 72'h04); run_cmd();
        chk("lit_run_set", dbg_run, 1'b1);
        load(1, 72'h06); run_cmd();
        load(1, 72'h03); run_cmd();
        load(1, 72'h05); run_cmd();
        chk("lit_seq_b0", got_tx[t0], 8'hA5);
        chk("lit_seq_b1", got_tx[t0+1], 8'h02);
        chk("lit_seq_b2", got_tx[t0+2], 8'hA5);
        chk("lit_seq_b3", got_tx[t0+3], 8'hA5);
        chk("lit_one_step", step_seen - s0, 1);
        chk("lit_run_cleared", dbg_run, 1'b0);

        // Invalid opcode, then a normal write.
        t0 = tx_wr; e0 = err_seen;
        load(1, 72'h7F); run_cmd();
        chk("lit_bad_resp", got_tx[t0], 8'hEE);
        chk("lit_bad_err", err_seen - e0, 1);
        load(9, 72'h01_00_00_00_20_01_02_03_04); run_cmd();

        // Inter-byte timeout in ADDR.
        e0 = err_seen;
        exp_err++;
        load(2, 72'h01_00);
        send_cmd(0);
        k = 0;
        while (err_seen == e0 && k < 60) begin tick(); k++; end
        chk("timeout_err_seen", err_seen, e0 + 1);
        chk("timeout_edges", err_edge - last_accept_edge, TMO);
        tick();
        chk("timeout_idle", busy_s, 1'b0);
        post_checks();
        chk("timeout_no_tx", tx_rd, tx_wr);
        txn++;
        $display("txn %0d op=01 abandoned after 2 bytes", txn);

        // Reset in the middle of DATA, with run set so its clear is visible.
        load(1, 72'h04); run_cmd();
        load(7, 72'h01_00_00_00_30_11_22);
        send_cmd(1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_run = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        chk("rx_ready_after_midreset", rx_ready, 1'b1);
        post_checks();
        txn++;
        $display("txn %0d op=01 discarded by reset", txn);
        load(9, 72'h01_00_00_00_30_CA_FE_F0_0D); run_cmd();
        load(5, 72'h02_00_00_00_30); run_cmd();

        // Random commands.
        for (int n = 0; n < 40; n++) begin
            dbg_halt = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 7)) * 32'd4;
            d = $urandom;
            case (r)
                0, 1: load(9, {8'h01, a, d});
                2, 3: load(5, {32'h0, 8'h02, a});
                4: load(1, 72'h03);
                5: load(1, 72'h04);
                6: load(1, 72'h05);
                7: load(1, 72'h06);
                8: begin
                    op = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(7, 255));
                    load(1, {64'h0, op});
                end
                default: load(5, {32'h0, 8'h02, 32'($urandom)});
            endcase
            run_cmd();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_cmd_bridge.md
DEBUG_CMD_BRIDGE -- requirements
Module: debug_cmd_bridge

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning clk cycles from the dbg_enable read pulse to valid dbg_rdata (range 1..7).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning idle cycles allowed between bytes of one command (range 1..65535).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rx_valid input 1, rx_data input 8, and rx_ready output 1, forming the inbound command byte stream.
REQ-006 SHALL have ports tx_valid output 1, tx_data output 8, and tx_ready input 1, forming the outbound response byte stream.
REQ-007 SHALL have ports dbg_enable output 1, dbg_rd_wr output 1 (1=write), dbg_address output 32, and dbg_wdata output 32, driving the debug access bus.
REQ-008 SHALL have ports dbg_rdata input 32 (read data) and dbg_halt input 1 (core halted status).
REQ-009 SHALL have ports dbg_step output 1 (single-step pulse) and dbg_run output 1 (run level).
REQ-010 SHALL have ports busy output 1 (command in progress) and err output 1 (one-cycle error pulse).

Function
REQ-011 SHALL transfer a byte only on a cycle with valid&&ready on that stream.
REQ-012 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-013 SHALL implement states IDLE, ADDR, DATA, EXEC, WAIT_RD, and RESP.
REQ-014 SHALL assert rx_ready only in IDLE, ADDR, and DATA.
REQ-015 SHALL, in IDLE, take the accepted byte as the opcode; 0x01 WRITE or 0x02 READ -> ADDR; 0x03 STEP, 0x04 RUN, 0x05 HALT, or 0x06 STATUS -> EXEC; any other value -> RESP with response 0xEE plus a one-cycle err pulse.
REQ-016 SHALL, in ADDR, shift 4 bytes MSB first into dbg_address using a 2-bit byte counter; after the 4th byte, WRITE -> DATA and READ -> EXEC.
REQ-017 SHALL, in DATA, shift 4 bytes MSB first into dbg_wdata; after the 4th byte -> EXEC.
REQ-018 SHALL, in EXEC, spend exactly one cycle and then: WRITE pulses dbg_enable=1 with dbg_rd_wr=1 for 1 cycle -> RESP with 0xA5.
REQ-019 SHALL, in EXEC for READ, pulse dbg_enable=1 with dbg_rd_wr=0 for 1 cycle -> WAIT_RD.
REQ-020 SHALL, in EXEC for STEP, pulse dbg_step for 1 cycle -> RESP with 0xA5.
REQ-021 SHALL, in EXEC, handle RUN by setting dbg_run=1 -> RESP with 0xA5, and HALT by clearing dbg_run=0 -> RESP with 0xA5.
REQ-022 SHALL, in EXEC for STATUS, sample dbg_halt -> RESP with one byte {6'b0, dbg_run, dbg_halt}.
REQ-023 SHALL, in WAIT_RD, count RD_LATENCY cycles after the enable pulse, capture dbg_rdata on the last count, then -> RESP with 4 bytes MSB first.
REQ-024 SHALL, in RESP, present response bytes in order, go to IDLE after the last byte is accepted, and apply no timeout while waiting on tx_ready.
REQ-025 SHALL hold dbg_address and dbg_wdata stable from EXEC until the next command loads them.
REQ-026 SHALL hold dbg_rd_wr at 0 except in the EXEC cycle of a WRITE.
REQ-027 SHALL hold dbg_run as a level register that changes only via the RUN and HALT opcodes.
REQ-028 SHALL, in ADDR or DATA, count cycles with no accepted byte; on reaching TIMEOUT_CYCLES, pulse err, abandon the command with no bus access and no response, and go to IDLE; any accepted byte clears the counter.
REQ-029 SHALL assert busy in every state other than IDLE.
REQ-030 SHALL never pulse dbg_enable and dbg_step in the same cycle.
REQ-031 SHALL keep at most one command outstanding, with no pipelining.

Reset
REQ-032 SHALL, while reset_n=0, immediately force state IDLE and byte counter, timeout counter, and latency counter to 0.
REQ-033 SHALL, while reset_n=0, immediately force rx_ready=0, tx_valid=0, tx_data=0x00, dbg_enable=0, dbg_rd_wr=0, dbg_address=0, dbg_wdata=0, dbg_step=0, dbg_run=0, busy=0, and err=0.
REQ-034 SHALL drive rx_ready=1 in the first cycle after reset_n deasserts.
REQ-035 SHALL, on reset asserted mid-command, discard the command with no bus pulse and no partial response.

Verification
REQ-036 SHALL cover: bytes 01 00 00 04 10 DE AD BE EF -> one dbg_enable pulse with rd_wr=1, address=0x00000410, wdata=0xDEADBEEF; tx 0xA5.
REQ-037 SHALL cover: bytes 02 00 00 00 08 with dbg_rdata=0x12345678 driven RD_LATENCY cycles after enable -> tx 12 34 56 78, with tx_ready toggled to check stall stability.
REQ-038 SHALL cover: bytes 04, 06, 03, 05 with dbg_halt=0 -> dbg_run=1, tx A5 02 A5 A5, one dbg_step pulse, dbg_run=0 at end.
REQ-039 SHALL cover: opcode 0x7F -> err pulse, tx 0xEE, then IDLE; a following valid write works.
REQ-040 SHALL cover: with TIMEOUT_CYCLES=16, bytes 01 00 then silence -> err exactly 16 cycles after the last byte, no dbg_enable, no tx.
REQ-041 SHALL cover: reset_n pulsed during DATA -> all outputs at reset values; next command executes normally.
